// File: rtl/pipe_arith_pkg.sv
// Shared constants and width helpers for the
// three-stage ((A+B)+(C-D))*D stream pipeline.
package pipe_arith_pkg;

  localparam int STAGES = 3;

  // Signed width holding A+B or C-D without wrap.
  function automatic int sum_w(input int n);
    return n + 2;
  endfunction

  // Signed width holding ((A+B)+(C-D))*D without wrap.
  function automatic int prod_w(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/pipe_arith_stream_if.sv
// Valid/ready operand and result stream bundle
// for pipe_arith_stream.
interface pipe_arith_stream_if #(
  parameter int N = 10
);

  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         sat_en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] F;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output A, B, C, D, sat_en,
    output in_valid, out_ready,
    input  in_ready, F, ovf, out_valid
  );

  modport slave (
    input  A, B, C, D, sat_en,
    input  in_valid, out_ready,
    output in_ready, F, ovf, out_valid
  );

endinterface

// File: rtl/pipe_arith_clamp.sv
// Result shaping: wrap or saturate a signed product
// into N bits, flagging any out-of-range value.
module pipe_arith_clamp #(
  parameter int N  = 10,
  parameter int PW = 23
) (
  input  logic signed [PW-1:0] p,
  input  logic                 sat_en,
  output logic [N-1:0]         f,
  output logic                 ovf
);

  logic hi;
  logic lo;

  assign lo  = p[PW-1];
  assign hi  = !p[PW-1] && (|p[PW-2:N]);
  assign ovf = hi || lo;

  always_comb begin
    f = p[N-1:0];
    if (sat_en) begin
      unique case (1'b1)
        lo:      f = '0;
        hi:      f = '1;
        default: f = p[N-1:0];
      endcase
    end
  end

endmodule

// File: rtl/pipe_arith_stream.sv
// Three-stage streaming ((A+B)+(C-D))*D with one
// global stall shared by every stage.
module pipe_arith_stream
  import pipe_arith_pkg::*;
#(
  parameter int N = 10
) (
  input logic                clk,
  input logic                rst,
  pipe_arith_stream_if.slave io
);

  localparam int SW = sum_w(N);
  localparam int XW = SW + 1;
  localparam int PW = prod_w(N);

  logic                 adv;
  logic                 v1, v2, v3;
  logic                 s1, s2, s3;
  logic signed [SW-1:0] x1, x2;
  logic signed [XW-1:0] x3;
  logic [N-1:0]         d1, d2;
  logic signed [PW-1:0] p3;

  logic signed [SW-1:0] x1_d, x2_d;
  logic signed [XW-1:0] x3_d;
  logic signed [PW-1:0] p_d;

  assign adv          = !(v3 && !io.out_ready);
  assign io.in_ready  = adv;
  assign io.out_valid = v3;

  assign x1_d = {{(SW-N){1'b0}}, io.A}
              + {{(SW-N){1'b0}}, io.B};
  assign x2_d = {{(SW-N){1'b0}}, io.C}
              - {{(SW-N){1'b0}}, io.D};

  // x1+x2 can reach ~3*2^N, one bit past the sum width.
  assign x3_d = {x1[SW-1], x1} + {x2[SW-1], x2};

  assign p_d = $signed({{(PW-XW){x3[XW-1]}}, x3})
             * $signed({{(PW-N){1'b0}}, d2});

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      d1 <= '0;
      d2 <= '0;
      p3 <= '0;
    end else if (adv) begin
      v1 <= io.in_valid;
      x1 <= x1_d;
      x2 <= x2_d;
      d1 <= io.D;
      s1 <= io.sat_en;
      v2 <= v1;
      x3 <= x3_d;
      d2 <= d1;
      s2 <= s1;
      v3 <= v2;
      // Bubbles leave the last result in place.
      if (v2) begin
        p3 <= p_d;
        s3 <= s2;
      end
    end
  end

  pipe_arith_clamp #(
    .N  (N),
    .PW (PW)
  ) u_clamp (
    .p      (p3),
    .sat_en (s3),
    .f      (io.F),
    .ovf    (io.ovf)
  );

endmodule

// File: doc/pipe_arith_stream.md
PIPE_ARITH_STREAM -- requirements
Module: pipe_arith_stream

Interface
REQ-001 SHALL have parameter N, default 10, meaning operand and result width in bits (N >= 4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports A, B, C, D, input, N each, unsigned operands.
REQ-005 SHALL have port sat_en, input, 1, per-item mode: 0 = truncate result modulo 2^N, 1 = saturate to [0, 2^N-1].
REQ-006 SHALL have port in_valid, input, 1; the operand set is offered when it is high.
REQ-007 SHALL have port in_ready, output, 1; the set is accepted on a rising edge where in_valid && in_ready.
REQ-008 SHALL have port F, output, N, the result.
REQ-009 SHALL have port ovf, output, 1; high when the exact result lies outside [0, 2^N-1].
REQ-010 SHALL have port out_valid, output, 1; F and ovf are meaningful when it is high.
REQ-011 SHALL have port out_ready, input, 1; the result is consumed on a rising edge where out_valid && out_ready.

Function
REQ-012 SHALL compute the exact result R = ((A+B) + (C-D)) * D, using signed intermediates wide enough that no intermediate wraps (N+2 bits for the sum, 2N+3 bits for the product).
REQ-013 Stage 1 SHALL register x1=A+B, x2=C-D, the D copy, sat_en and valid.
REQ-014 Stage 2 SHALL register x3=x1+x2, the D copy, sat_en and valid.
REQ-015 Stage 3 SHALL register the product, the clamp/truncate result, ovf, and out_valid.
REQ-016 Latency SHALL be exactly 3 rising edges from acceptance to out_valid when there is no backpressure.
REQ-017 Throughput SHALL be one item per cycle when out_ready is held high.
REQ-018 The global advance signal SHALL be defined as adv = !(out_valid && !out_ready).
REQ-019 When adv=1, all three stages SHALL shift. When adv=0, all stages SHALL hold, and F, ovf and out_valid SHALL stay stable.
REQ-020 in_ready SHALL equal adv; this is a combinational path from out_ready.
REQ-021 A cycle with in_valid=0 and adv=1 SHALL insert a bubble (valid=0) into stage 1; bubbles are not collapsed.
REQ-022 When sat_en=0, F SHALL be R[N-1:0] (two's-complement wrap for negative R).
REQ-023 When sat_en=1, F SHALL be 2^N-1 if R > 2^N-1, 0 if R < 0, and R otherwise.
REQ-024 ovf SHALL be computed identically in both modes; sat_en affects F only.
REQ-025 Each item SHALL use the sat_en value sampled with its own operands; mode changes never affect items already in flight.
REQ-026 While out_valid=0, F and ovf SHALL hold their last values and are don't-care to the consumer.

Reset
REQ-027 On a rising edge with rst=1, all stage valids, out_valid, F and ovf SHALL become 0, and all data registers SHALL become 0.
REQ-028 A reset mid-operation SHALL discard every in-flight item; no result from before the reset may appear afterwards.
REQ-029 rst SHALL take priority over adv and in_valid on the same edge; no input is accepted on that edge.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-031 SHALL use a shared package pipe_arith_pkg holding the stage-count constant (3) and the width helper functions for the sum and product widths.
REQ-032 SHALL use one sub-module, pipe_arith_clamp: combinational, taking the signed product and sat_en, producing F and ovf, instantiated in stage 3.

Verification
REQ-033 With N=10 and out_ready=1, SHALL stream these sets back-to-back with sat_en=0:
- (10,12,6,3) -> F=75
- (10,10,5,3) -> F=66
- (20,11,1,4) -> F=112
- (15,10,8,2) -> F=62
- (8,15,5,0) -> F=0
- (30,1,2,4) -> F=116

Each result SHALL appear exactly 3 edges after its input, with ovf=0.
REQ-034 The bench SHALL apply (1023,1023,1023,1023). With sat_en=1 -> F=1023, ovf=1. With sat_en=0 -> F=R[9:0], ovf=1.
REQ-035 The bench SHALL apply (0,0,0,5), giving R=-25. With sat_en=0 -> F=999, ovf=1. With sat_en=1 -> F=0, ovf=1.
REQ-036 Backpressure: stream 4 items, hold out_ready=0 for 5 cycles once the first result is valid. Required response:
- F and out_valid stay frozen;
- in_ready=0 throughout;
- after release, all 4 results emerge in order with none lost or duplicated.
REQ-037 Reset: assert rst for 1 cycle while 3 items are in flight. Required response:
- out_valid=0 and F=0 on the next cycle;
- no pre-reset result ever appears;
- a new item accepted afterwards emerges 3 edges later.
REQ-038 Bubbles: alternate in_valid 1/0 over 8 cycles. Required response:
- out_valid shows the same 1/0 pattern delayed by 3 cycles;
- toggling sat_en per item yields the per-item F values defined in REQ-022 and REQ-023.
